// File: rtl/cpu_interrupt_ctrl.sv
// Interrupt, halt, LED and cycle-counter control for the pipelined CPU.
// Optional build macro IRQ_EDGE_EN: requests latch on IRQ rising edges instead of levels.
module cpu_interrupt_ctrl #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] H0_ADDR = 32'h0000_0100,
  parameter logic [WIDTH-1:0] H1_ADDR = 32'h0000_0200,
  parameter logic [WIDTH-1:0] H2_ADDR = 32'h0000_0300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       IRQ,
  input  logic             GO,
  input  logic             halt_req,
  input  logic             led_we,
  input  logic [WIDTH-1:0] led_wdata,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             mret,
  output logic             int_take,
  output logic [WIDTH-1:0] int_target,
  output logic [WIDTH-1:0] epc_out,
  output logic [2:0]       IRW,
  output logic             stall,
  output logic [WIDTH-1:0] LedData,
  output logic [WIDTH-1:0] clocks
);

  // Level encoding: NONE is 0 and source i is i+1, so a plain compare gives priority.
  localparam logic [1:0] LVL_NONE = 2'd0;

  logic [2:0]       pend_q, pend_d;
  logic [2:0]       insvc_q, insvc_d;
  logic [1:0]       level_q, level_d;
  logic             int_take_q;
  logic [WIDTH-1:0] int_target_q, int_target_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] clocks_q;
  logic [WIDTH-1:0] slot_epc_q  [0:2];
  logic [1:0]       slot_prev_q [0:2];

  logic [2:0] irq_set;
  logic [1:0] cand_lvl, cand_idx, cur_idx;
  logic       accept, mret_ok;

`ifdef IRQ_EDGE_EN
  logic [2:0] irq_prev_q;

  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= IRQ;
  end

  assign irq_set = IRQ & ~irq_prev_q;
`else
  assign irq_set = IRQ;
`endif

  always_comb begin
    if      (pend_q[2]) cand_lvl = 2'd3;
    else if (pend_q[1]) cand_lvl = 2'd2;
    else if (pend_q[0]) cand_lvl = 2'd1;
    else                cand_lvl = LVL_NONE;
  end

  assign cand_idx = cand_lvl - 2'd1;
  assign cur_idx  = level_q - 2'd1;
  assign accept   = (cand_lvl > level_q) && ex_valid && !mret && !int_take_q;
  assign mret_ok  = mret && (level_q != LVL_NONE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pend_d       = pend_q;
    insvc_d      = insvc_q;
    level_d      = level_q;
    int_target_d = int_target_q;
    if (mret_ok) begin
      insvc_d[cur_idx] = 1'b0;
      level_d          = slot_prev_q[cur_idx];
    end else if (accept) begin
      insvc_d[cand_idx] = 1'b1;
      pend_d[cand_idx]  = 1'b0;
      level_d           = cand_lvl;
      case (cand_lvl)
        2'd3:    int_target_d = H2_ADDR;
        2'd2:    int_target_d = H1_ADDR;
        default: int_target_d = H0_ADDR;
      endcase
    end
    // A request seen at the accept edge re-pends the same source.
    pend_d = pend_d | irq_set;

    if      (GO)       halted_d = 1'b0;
    else if (accept)   halted_d = 1'b0;
    else if (halt_req) halted_d = 1'b1;
    else               halted_d = halted_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      insvc_q      <= '0;
      level_q      <= LVL_NONE;
      int_take_q   <= 1'b0;
      int_target_q <= '0;
      halted_q     <= 1'b0;
      led_q        <= '0;
      clocks_q     <= '0;
    end else begin
      pend_q       <= pend_d;
      insvc_q      <= insvc_d;
      level_q      <= level_d;
      int_take_q   <= accept;
      int_target_q <= int_target_d;
      halted_q     <= halted_d;
      if (led_we) led_q <= led_wdata;
      clocks_q     <= clocks_q + 1'b1;
    end
  end

  // NOTE: the save stack is not reset; a slot is only read after an accept has written it.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_epc_q[cand_idx]  <= ex_pc;
      slot_prev_q[cand_idx] <= level_q;
    end
  end

  assign int_take   = int_take_q;
  assign int_target = int_target_q;
  assign epc_out    = mret_ok ? slot_epc_q[cur_idx] : '0;
  assign IRW        = pend_q | insvc_q;
  assign stall      = halted_q;
  assign LedData    = led_q;
  assign clocks     = clocks_q;

endmodule

// File: tb/tb_cpu_interrupt_ctrl.sv
// Table-driven bench for cpu_interrupt_ctrl, plus a narrow instance for counter wrap.
module tb_cpu_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  IRQ;
  logic        GO, halt_req, led_we, ex_valid, mret;
  logic [31:0] led_wdata, ex_pc;
  logic        int_take, stall;
  logic [31:0] int_target, epc_out, LedData, clocks;
  logic [2:0]  IRW;

  logic        int_take8, stall8;
  logic [7:0]  int_target8, epc_out8, LedData8, clocks8;
  logic [2:0]  IRW8;

  always #5 clk = ~clk;

  cpu_interrupt_ctrl u_dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .GO(GO), .halt_req(halt_req),
    .led_we(led_we), .led_wdata(led_wdata), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .mret(mret), .int_take(int_take), .int_target(int_target), .epc_out(epc_out),
    .IRW(IRW), .stall(stall), .LedData(LedData), .clocks(clocks)
  );

  cpu_interrupt_ctrl #(
    .WIDTH(8), .H0_ADDR(8'h10), .H1_ADDR(8'h20), .H2_ADDR(8'h30)
  ) u_dut8 (
    .clk(clk), .rst(rst), .IRQ(IRQ), .GO(GO), .halt_req(halt_req),
    .led_we(led_we), .led_wdata(led_wdata[7:0]), .ex_valid(ex_valid), .ex_pc(ex_pc[7:0]),
    .mret(mret), .int_take(int_take8), .int_target(int_target8), .epc_out(epc_out8),
    .IRW(IRW8), .stall(stall8), .LedData(LedData8), .clocks(clocks8)
  );

  typedef struct {
    logic [2:0]  irq;
    logic        go, halt, we;
    logic [31:0] wdata;
    logic        exv;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] e_epc;
    logic        e_take;
    logic [31:0] e_tgt;
    logic [2:0]  e_irw;
    logic        e_stall;
    logic [31:0] e_led;
  } vec_t;

  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycles   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic [2:0] irq, input logic go, input logic halt, input logic we,
                   input logic [31:0] wdata, input logic exv, input logic [31:0] pc,
                   input logic mr, input logic [31:0] e_epc, input logic e_take,
                   input logic [31:0] e_tgt, input logic [2:0] e_irw, input logic e_stall,
                   input logic [31:0] e_led);
    vec_t r;
    r.irq = irq; r.go = go; r.halt = halt; r.we = we; r.wdata = wdata;
    r.exv = exv; r.pc = pc; r.mret = mr;
    r.e_epc = e_epc; r.e_take = e_take; r.e_tgt = e_tgt; r.e_irw = e_irw;
    r.e_stall = e_stall; r.e_led = e_led;
    vecs.push_back(r);
  endtask

  task automatic idle_inputs();
    IRQ = '0; GO = 0; halt_req = 0; led_we = 0; led_wdata = '0;
    ex_valid = 0; ex_pc = '0; mret = 0;
  endtask

  task automatic apply(input vec_t r, input int idx);
    IRQ = r.irq; GO = r.go; halt_req = r.halt; led_we = r.we; led_wdata = r.wdata;
    ex_valid = r.exv; ex_pc = r.pc; mret = r.mret;
    #2;
    check($sformatf("row%0d epc_out", idx), epc_out, r.e_epc);
    @(posedge clk);
    cycles++;
    #1;
    check($sformatf("row%0d int_take", idx), {31'd0, int_take}, {31'd0, r.e_take});
    check($sformatf("row%0d int_target", idx), int_target, r.e_tgt);
    check($sformatf("row%0d IRW", idx), {29'd0, IRW}, {29'd0, r.e_irw});
    check($sformatf("row%0d stall", idx), {31'd0, stall}, {31'd0, r.e_stall});
    check($sformatf("row%0d LedData", idx), LedData, r.e_led);
    check($sformatf("row%0d clocks", idx), clocks, cycles);
  endtask

  initial begin
    // idle after reset: clocks 1..5, everything else 0
    for (int i = 0; i < 5; i++) v(0,0,0,0,0,0,0,0, 0,0,0,3'b000,0,0);
    // single IRQ0
    v(3'b001,0,0,0,0,0,0,0,          0,0,'h000,3'b001,0,0);
    v(3'b000,0,0,0,0,1,'h40,0,       0,1,'h100,3'b001,0,0);
    v(3'b000,0,0,0,0,1,'h44,0,       0,0,'h100,3'b001,0,0);
    v(3'b000,0,0,0,0,0,0,1,      'h40,0,'h100,3'b000,0,0);
    // nesting 0 -> 1 -> 2, then three mrets
    v(3'b001,0,0,0,0,0,0,0,          0,0,'h100,3'b001,0,0);
    v(3'b000,0,0,0,0,1,'h40,0,       0,1,'h100,3'b001,0,0);
    v(3'b010,0,0,0,0,0,0,0,          0,0,'h100,3'b011,0,0);
    v(3'b000,0,0,0,0,1,'h104,0,      0,1,'h200,3'b011,0,0);
    v(3'b100,0,0,0,0,0,0,0,          0,0,'h200,3'b111,0,0);
    v(3'b000,0,0,0,0,1,'h208,0,      0,1,'h300,3'b111,0,0);
    v(3'b000,0,0,0,0,1,'h304,0,      0,0,'h300,3'b111,0,0);
    v(3'b000,0,0,0,0,0,0,1,     'h208,0,'h300,3'b011,0,0);
    v(3'b000,0,0,0,0,0,0,1,     'h104,0,'h300,3'b001,0,0);
    v(3'b000,0,0,0,0,0,0,1,      'h40,0,'h300,3'b000,0,0);
    // mret with no level is ignored
    v(3'b000,0,0,0,0,0,0,1,          0,0,'h300,3'b000,0,0);
    // lower priority held off during IRQ2 service
    v(3'b100,0,0,0,0,0,0,0,          0,0,'h300,3'b100,0,0);
    v(3'b000,0,0,0,0,1,'h80,0,       0,1,'h300,3'b100,0,0);
    v(3'b001,0,0,0,0,1,'h304,0,      0,0,'h300,3'b101,0,0);
    v(3'b000,0,0,0,0,1,'h308,0,      0,0,'h300,3'b101,0,0);
    v(3'b000,0,0,0,0,1,'h30C,1,  'h80,0,'h300,3'b001,0,0);
    v(3'b000,0,0,0,0,1,'h84,0,       0,1,'h100,3'b001,0,0);
    v(3'b000,0,0,0,0,0,0,1,      'h84,0,'h100,3'b000,0,0);
    // mret and pending IRQ1 in the same cycle
    v(3'b001,0,0,0,0,0,0,0,          0,0,'h100,3'b001,0,0);
    v(3'b000,0,0,0,0,1,'h50,0,       0,1,'h100,3'b001,0,0);
    v(3'b010,0,0,0,0,0,0,0,          0,0,'h100,3'b011,0,0);
    v(3'b000,0,0,0,0,1,'h54,1,   'h50,0,'h100,3'b010,0,0);
    v(3'b000,0,0,0,0,1,'h58,0,       0,1,'h200,3'b010,0,0);
    v(3'b000,0,0,0,0,0,0,1,      'h58,0,'h200,3'b000,0,0);
    // no accept in the cycle right after a take
    v(3'b001,0,0,0,0,0,0,0,          0,0,'h200,3'b001,0,0);
    v(3'b010,0,0,0,0,1,'h60,0,       0,1,'h100,3'b011,0,0);
    v(3'b000,0,0,0,0,1,'h100,0,      0,0,'h100,3'b011,0,0);
    v(3'b000,0,0,0,0,1,'h104,0,      0,1,'h200,3'b011,0,0);
    v(3'b000,0,0,0,0,0,0,1,     'h104,0,'h200,3'b001,0,0);
    v(3'b000,0,0,0,0,0,0,1,      'h60,0,'h200,3'b000,0,0);
    // LED and halt/GO, wake on interrupt
    v(3'b000,0,0,1,DB,0,0,0,         0,0,'h200,3'b000,0,DB);
    v(3'b000,0,1,0,0,0,0,0,          0,0,'h200,3'b000,1,DB);
    v(3'b000,0,0,0,0,0,0,0,          0,0,'h200,3'b000,1,DB);
    v(3'b000,1,1,0,0,0,0,0,          0,0,'h200,3'b000,0,DB);
    v(3'b000,0,1,0,0,0,0,0,          0,0,'h200,3'b000,1,DB);
    v(3'b100,0,0,0,0,0,0,0,          0,0,'h200,3'b100,1,DB);
    v(3'b000,0,0,0,0,1,'h70,0,       0,1,'h300,3'b100,0,DB);
    v(3'b000,0,0,0,0,0,0,1,      'h70,0,'h300,3'b000,0,DB);
    // held-high IRQ0
    v(3'b001,0,0,0,0,0,0,0,          0,0,'h300,3'b001,0,DB);
    v(3'b001,0,0,0,0,1,'h90,0,       0,1,'h100,3'b001,0,DB);
`ifdef IRQ_EDGE_EN
    v(3'b001,0,0,0,0,0,0,1,      'h90,0,'h100,3'b000,0,DB);
    v(3'b000,0,0,0,0,1,'h94,0,       0,0,'h100,3'b000,0,DB);
    v(3'b000,0,0,0,0,0,0,1,          0,0,'h100,3'b000,0,DB);
`else
    v(3'b001,0,0,0,0,0,0,1,      'h90,0,'h100,3'b001,0,DB);
    v(3'b000,0,0,0,0,1,'h94,0,       0,1,'h100,3'b001,0,DB);
    v(3'b000,0,0,0,0,0,0,1,      'h94,0,'h100,3'b000,0,DB);
`endif

    // reset with active inputs still yields all-zero outputs
    rst = 1'b1;
    idle_inputs();
    IRQ = 3'b111; halt_req = 1; led_we = 1; led_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("reset int_take", {31'd0, int_take}, 32'd0);
    check("reset int_target", int_target, 32'd0);
    check("reset IRW", {29'd0, IRW}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset LedData", LedData, 32'd0);
    check("reset clocks", clocks, 32'd0);
    check("reset epc_out", epc_out, 32'd0);
    idle_inputs();
    rst = 1'b0;
    cycles = 0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // narrow counter wraps 255 -> 0
    idle_inputs();
    while ((cycles % 256) != 255) begin
      @(posedge clk);
      cycles++;
    end
    #1;
    check("wrap clocks8 at max", {24'd0, clocks8}, 32'h0000_00FF);
    check("wrap clocks wide", clocks, cycles);
    @(posedge clk);
    cycles++;
    #1;
    check("wrap clocks8 to zero", {24'd0, clocks8}, 32'd0);
    check("wrap clocks wide next", clocks, cycles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
